pattern_history_table: RTL and testbench

Second level of the two-level local branch predictor. Consumes the 4-bit local history produced by the branch history table and indexes an array of 2-bit saturating counters with {PC bits, history}. Delivers a taken/not-taken prediction to the fetch stage in the same cycle and trains the counters when the branch resolves in EX. Includes a reset-time initialisation sweep and a saturating misprediction counter for performance monitoring.

---
 rtl/bp_pkg.sv | 26 ++
 rtl/pattern_history_table_if.sv | 32 +++
 rtl/sat_counter2.sv | 20 ++
 rtl/pattern_history_table.sv | 100 ++++++++++
 tb/tb_pattern_history_table.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Branch predictor shared definitions (BHT, PHT, BTB).
// Holds index geometry, 2-bit counter encodings and the PHT FSM state type.
package bp_pkg;

  localparam int unsigned HIST_WIDTH  = 4;
  localparam int unsigned PC_BITS     = 4;
  localparam int unsigned INDEX_WIDTH = PC_BITS + HIST_WIDTH;
  localparam int unsigned PHT_DEPTH   = 1 << INDEX_WIDTH;
  localparam int unsigned CNT_WIDTH   = 16;

  // 2-bit saturating counter encodings
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam ctr_t PHT_INIT = WNT;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pht_state_t;

endpackage

// File: rtl/pattern_history_table_if.sv
// Fetch/EX interface of the pattern history table.
// master: pipeline side (drives PCs, histories, resolved outcome).
// slave : PHT side (returns prediction, ready and mispredict count).
interface pattern_history_table_if;
  import bp_pkg::*;

  logic [31:0]           PC_Plus4;
  logic [HIST_WIDTH-1:0] Rhistory;
  logic [31:0]           ID_EX_PC;
  logic [HIST_WIDTH-1:0] ID_EX_Rhistory;
  logic                  ID_EX_Branch;
  logic                  PCSrc;
  logic                  ID_EX_BPred;
  logic                  ID_EX_BPredValid;
  logic                  BPred;
  logic                  BPredValid;
  logic                  pht_ready;
  logic [CNT_WIDTH-1:0]  mispredict_count;

  modport master (
    output PC_Plus4, Rhistory, ID_EX_PC, ID_EX_Rhistory, ID_EX_Branch,
           PCSrc, ID_EX_BPred, ID_EX_BPredValid,
    input  BPred, BPredValid, pht_ready, mispredict_count
  );

  modport slave (
    input  PC_Plus4, Rhistory, ID_EX_PC, ID_EX_Rhistory, ID_EX_Branch,
           PCSrc, ID_EX_BPred, ID_EX_BPredValid,
    output BPred, BPredValid, pht_ready, mispredict_count
  );

endinterface

// File: rtl/sat_counter2.sv
// Combinational next value of a 2-bit saturating counter.
// Ports: cur (current value), taken (direction), nxt (next value).
module sat_counter2
  import bp_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken && (cur != 2'(ST))) begin
      nxt = cur + 2'd1;
    end else if (!taken && (cur != 2'(SNT))) begin
      nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/pattern_history_table.sv
// Second-level local-history predictor: 2-bit counters indexed by {PC, history}.
// Ports: clk, reset (sync, active-high), bus (slave modport): fetch-side
// lookup, EX-side training, prediction outputs and mispredict counter.
module pattern_history_table
  import bp_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  pattern_history_table_if.slave   bus
);

  logic [1:0]             pht [PHT_DEPTH];
  pht_state_t             state;
  logic [INDEX_WIDTH-1:0] init_ptr;
  logic                   ready;
  logic [CNT_WIDTH-1:0]   miss_cnt;

  logic [INDEX_WIDTH-1:0] ridx;
  logic [INDEX_WIDTH-1:0] widx;
  logic [1:0]             upd_val;
  logic                   pht_we;
  logic [INDEX_WIDTH-1:0] pht_waddr;
  logic [1:0]             pht_wdata;
  logic                   mispredict;

  assign ridx = {bus.PC_Plus4[PC_BITS+1:2], bus.Rhistory};
  assign widx = {bus.ID_EX_PC[PC_BITS+1:2], bus.ID_EX_Rhistory};

  assign mispredict = bus.ID_EX_Branch && bus.ID_EX_BPredValid &&
                      (bus.ID_EX_BPred != bus.PCSrc);

  sat_counter2 u_sat (
    .cur   (pht[widx]),
    .taken (bus.PCSrc),
    .nxt   (upd_val)
  );

  // Single array write port: init sweep in INIT, training in RUN, nothing under reset
  always_comb begin
    pht_we    = 1'b0;
    pht_waddr = widx;
    pht_wdata = upd_val;
    if (!reset) begin
      if (state == INIT) begin
        pht_we    = 1'b1;
        pht_waddr = init_ptr;
        pht_wdata = 2'(PHT_INIT);
      end else if (bus.ID_EX_Branch) begin
        pht_we = 1'b1;
      end
    end
  end

  // Counter array has no reset; the INIT sweep establishes its contents
  always_ff @(posedge clk) begin
    if (pht_we) begin
      pht[pht_waddr] <= pht_wdata;
    end
  end

  // Control FSM, ready flag and saturating mispredict counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_ptr <= '0;
      ready    <= 1'b0;
      miss_cnt <= '0;
    end else begin
      case (state)
        INIT: begin
          init_ptr <= init_ptr + 1'b1;
          if (init_ptr == INDEX_WIDTH'(PHT_DEPTH - 1)) begin
            state <= RUN;
            ready <= 1'b1;
          end
        end
        RUN: begin
          if (mispredict && (miss_cnt != '1)) begin
            miss_cnt <= miss_cnt + 1'b1;
          end
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // Lookup is zero-latency; a same-cycle update is seen on the next cycle
  assign bus.BPred            = ready & pht[ridx][1];
  assign bus.BPredValid       = ready;
  assign bus.pht_ready        = ready;
  assign bus.mispredict_count = miss_cnt;

  // PC bits outside the index do not affect prediction
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.PC_Plus4[31:PC_BITS+2], bus.PC_Plus4[1:0],
                            bus.ID_EX_PC[31:PC_BITS+2], bus.ID_EX_PC[1:0]};

endmodule

// File: tb/tb_pattern_history_table.sv
// Randomized and directed bench for pattern_history_table.
// Driver issues one cycle of stimulus at a time and queues the expected
// outputs from a behavioural model; a negedge monitor pops and compares.
module tb_pattern_history_table;
  import bp_pkg::*;

  logic clk;
  logic reset;

  pattern_history_table_if bus();

  pattern_history_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          bpred;
    bit          ready;
    int unsigned cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  // Behavioural reference model
  int unsigned mem [256];
  bit          m_known = 1'b0;
  bit          m_ready = 1'b0;
  int          m_init_left = 0;
  int unsigned m_cnt = 0;

  function automatic int unsigned pht_index(input logic [31:0] pc, input logic [3:0] h);
    return ((pc / 4) % 16) * 16 + int'(h);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive, queue expectation, advance model, wait for the edge
  task automatic cyc(input bit rst, input logic [31:0] pc, input logic [3:0] rh,
                     input logic [31:0] epc, input logic [3:0] erh,
                     input bit br, input bit src, input bit bp, input bit bpv);
    exp_t        e;
    int unsigned w;
    reset                = rst;
    bus.PC_Plus4         = pc;
    bus.Rhistory         = rh;
    bus.ID_EX_PC         = epc;
    bus.ID_EX_Rhistory   = erh;
    bus.ID_EX_Branch     = br;
    bus.PCSrc            = src;
    bus.ID_EX_BPred      = bp;
    bus.ID_EX_BPredValid = bpv;
    if (m_known) begin
      e.ready = m_ready;
      e.bpred = m_ready && (mem[pht_index(pc, rh)] >= 2);
      e.cnt   = m_cnt;
      sbq.push_back(e);
    end
    if (rst) begin
      m_known     = 1'b1;
      m_ready     = 1'b0;
      m_init_left = 256;
      m_cnt       = 0;
    end else if (m_known && !m_ready) begin
      m_init_left--;
      if (m_init_left == 0) begin
        m_ready = 1'b1;
        foreach (mem[i]) mem[i] = 1;
      end
    end else if (m_known) begin
      w = pht_index(epc, erh);
      if (br) begin
        if (src) mem[w] = (mem[w] == 3) ? 3 : mem[w] + 1;
        else     mem[w] = (mem[w] == 0) ? 0 : mem[w] - 1;
      end
      if (br && bpv && (bp != src) && (m_cnt < 65535)) m_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_upper(input logic [31:0] pc);
    return ($urandom & 32'hFFFF_FFC0) | (pc & 32'h0000_003C) | ($urandom & 32'h3);
  endfunction

  // Idle cycle: random lookup, EX fields random but no branch
  task automatic idle(input logic [31:0] pc, input logic [3:0] rh);
    cyc(1'b0, rand_upper(pc), rh, $urandom, 4'($urandom), 1'b0,
        1'($urandom), 1'($urandom), 1'($urandom));
  endtask

  // Training cycle on PC 0x10 / history 1010 (index 0x4A), lookup on same index
  task automatic train4a(input bit src, input bit bp, input bit bpv);
    cyc(1'b0, rand_upper(32'h10), 4'b1010, rand_upper(32'h10), 4'b1010,
        1'b1, src, bp, bpv);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("pht_ready", 32'(bus.pht_ready), 32'(e.ready));
      check("BPredValid", 32'(bus.BPredValid), 32'(e.ready));
      check("BPred", 32'(bus.BPred), 32'(e.bpred));
      check("mispredict_count", 32'(bus.mispredict_count), e.cnt);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc, epc;
    logic [3:0]  rh, erh;
    reset = 1'b1;
    #1;
    // 1: reset, 256-cycle init sweep, then all entries weakly not-taken
    cyc(1'b1, 32'h0, 4'h0, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (256) idle($urandom, 4'($urandom));
    repeat (20) idle($urandom, 4'($urandom));

    // 2/4: collision on 0x4A then saturation at strongly taken
    train4a(1'b1, 1'b0, 1'b0);
    train4a(1'b1, 1'b0, 1'b0);
    train4a(1'b1, 1'b0, 1'b0);
    train4a(1'b0, 1'b0, 1'b0);
    idle(32'h10, 4'b1010);

    // 3: back down to strongly not-taken, unlabelled mispredicts not counted
    train4a(1'b0, 1'b1, 1'b0);
    train4a(1'b0, 1'b1, 1'b0);
    train4a(1'b0, 1'b1, 1'b0);
    train4a(1'b0, 1'b1, 1'b0);
    idle(32'h10, 4'b1010);

    // 5: mispredict counting and saturation
    repeat (3) cyc(1'b0, $urandom, 4'($urandom), 32'h24, 4'h3, 1'b1, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, $urandom, 4'($urandom), 32'h24, 4'h3, 1'b1, 1'b1, 1'b1, 1'b1);
    idle($urandom, 4'($urandom));
    force dut.miss_cnt = 16'hFFFE;
    m_cnt = 32'hFFFE;
    idle($urandom, 4'($urandom));
    release dut.miss_cnt;
    repeat (3) cyc(1'b0, $urandom, 4'($urandom), 32'h28, 4'h5, 1'b1, 1'b0, 1'b1, 1'b1);
    idle($urandom, 4'($urandom));

    // 6: train 0x4A, reset, re-reset at init pointer 100, full sweep again
    repeat (3) train4a(1'b1, 1'b0, 1'b1);
    idle(32'h10, 4'b1010);
    cyc(1'b1, 32'h10, 4'b1010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (100) idle(32'h10, 4'b1010);
    cyc(1'b1, 32'h10, 4'b1010, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (256) idle(32'h10, 4'b1010);
    repeat (3) idle(32'h10, 4'b1010);

    // Random phase on a narrow index pool to provoke collisions and saturation
    for (int i = 0; i < 3000; i++) begin
      pc  = rand_upper(32'($urandom_range(0, 3)) << 2);
      rh  = 4'($urandom_range(0, 3));
      epc = rand_upper(32'($urandom_range(0, 3)) << 2);
      erh = 4'($urandom_range(0, 3));
      cyc(($urandom_range(0, 1499) == 0), pc, rh, epc, erh,
          ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
